data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_pkg.sv | 16 +
 rtl/mem_lane_align.sv | 79 +++++++
 rtl/data_mem_responder.sv | 132 +++++++++++++
 tb/tb_data_mem_responder.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// rtl/data_mem_pkg.sv - state encoding and funct3 access constants for data_mem_responder
package data_mem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane selection, extension and access legality for one word
module mem_lane_align
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic              is_wr,
  input  logic [1:0]        byte_off,
  input  logic [31:0]       word_in,
  input  logic [31:0]       store_in,
  output logic [DATA_W-1:0] load_out,
  output logic [31:0]       store_lanes,
  output logic [3:0]        byte_en,
  output logic              illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Misaligned halfword/word, unsigned stores and reserved encodings are illegal
  always_comb begin
    case (funct3)
      F3_B:    illegal = 1'b0;
      F3_H:    illegal = byte_off[0];
      F3_W:    illegal = (byte_off != 2'd0);
      F3_BU:   illegal = is_wr;
      F3_HU:   illegal = is_wr | byte_off[0];
      default: illegal = 1'b1;
    endcase
  end

  // Pick the addressed byte and halfword out of the aligned word
  always_comb begin
    case (byte_off)
      2'd0:    byte_sel = word_in[7:0];
      2'd1:    byte_sel = word_in[15:8];
      2'd2:    byte_sel = word_in[23:16];
      default: byte_sel = word_in[31:24];
    endcase
    half_sel = byte_off[1] ? word_in[31:16] : word_in[15:0];
  end

  // Load result: sign- or zero-extended; zero for stores and illegal accesses
  always_comb begin
    load_out = '0;
    if (!illegal && !is_wr) begin
      case (funct3)
        F3_B:    load_out = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
        F3_H:    load_out = {{(DATA_W-16){half_sel[15]}}, half_sel};
        F3_W:    load_out = DATA_W'(word_in);
        F3_BU:   load_out = {{(DATA_W-8){1'b0}}, byte_sel};
        F3_HU:   load_out = {{(DATA_W-16){1'b0}}, half_sel};
        default: load_out = '0;
      endcase
    end
  end

  // Store data replicated across lanes; enables gate which bytes actually change
  always_comb begin
    store_lanes = store_in;
    byte_en     = 4'b0000;
    if (!illegal && is_wr) begin
      case (funct3)
        F3_B: begin
          store_lanes = {4{store_in[7:0]}};
          byte_en     = 4'b0001 << byte_off;
        end
        F3_H: begin
          store_lanes = {2{store_in[15:0]}};
          byte_en     = byte_off[1] ? 4'b1100 : 4'b0011;
        end
        F3_W:    byte_en = 4'b1111;
        default: byte_en = 4'b0000;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - byte-addressed data memory with fixed-latency request/response handshake
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        funct3,
  output logic              busy,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_done,
  output logic              err
);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                is_wr_q, is_wr_d;
  logic [DATA_W-1:0]   rd_hold_q, rd_hold_d;

  logic [7:0]          mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-3:0]   word_base;
  logic [31:0]         mem_word;
  logic [DATA_W-1:0]   load_out;
  logic [31:0]         store_lanes;
  logic [3:0]          byte_en;
  logic                illegal;
  logic                in_resp;

  assign word_base = addr_q[ADDR_W-1:2];
  assign in_resp   = (state_q == ST_RESP);
  assign mem_word  = {mem[{word_base, 2'd3}], mem[{word_base, 2'd2}],
                      mem[{word_base, 2'd1}], mem[{word_base, 2'd0}]};

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .funct3      (funct3_q),
    .is_wr       (is_wr_q),
    .byte_off    (addr_q[1:0]),
    .word_in     (mem_word),
    .store_in    (wdata_q[31:0]),
    .load_out    (load_out),
    .store_lanes (store_lanes),
    .byte_en     (byte_en),
    .illegal     (illegal)
  );

  // Accept in IDLE (store wins over load), count down in WAIT, respond for one cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    is_wr_d   = is_wr_q;
    rd_hold_d = rd_hold_q;
    case (state_q)
      ST_IDLE: begin
        if (rd || wr) begin
          addr_d   = addr;
          wdata_d  = wr_data;
          funct3_d = funct3;
          is_wr_d  = wr;
          cnt_d    = 3'(LATENCY);
          state_d  = (LATENCY == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        if (!is_wr_q) rd_hold_d = load_out;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and capture registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= 3'd0;
      is_wr_q   <= 1'b0;
      rd_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      is_wr_q   <= is_wr_d;
      rd_hold_q <= rd_hold_d;
    end
  end

  // Storage commits only in RESP and keeps its contents across reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (in_resp && byte_en[i]) mem[{word_base, 2'(i)}] <= store_lanes[8*i +: 8];
    end
  end

  // Response pulses and load data presented during the RESP cycle
  always_comb begin
    busy     = (state_q != ST_IDLE);
    err      = in_resp & illegal;
    rd_valid = in_resp & ~is_wr_q & ~illegal;
    wr_done  = in_resp & is_wr_q & ~illegal;
    if (err)                      rd_data = '0;
    else if (in_resp && !is_wr_q) rd_data = load_out;
    else                          rd_data = rd_hold_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rd1, wr1, rd0, wr0;
  logic [8:0]  addr1, addr0;
  logic [31:0] wdat1, wdat0;
  logic [2:0]  f31, f30;
  logic        busy1, rdv1, wdn1, err1, busy0, rdv0, wdn0, err0;
  logic [31:0] rdata1, rdata0;

  logic        use0;
  logic        m_busy, m_rdv, m_wdn, m_err;
  logic [31:0] m_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder #(.DATA_W(32), .ADDR_W(9), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .rd(rd1), .wr(wr1), .addr(addr1), .wr_data(wdat1),
    .funct3(f31), .busy(busy1), .rd_data(rdata1), .rd_valid(rdv1), .wr_done(wdn1), .err(err1)
  );

  data_mem_responder #(.DATA_W(32), .ADDR_W(9), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .rd(rd0), .wr(wr0), .addr(addr0), .wr_data(wdat0),
    .funct3(f30), .busy(busy0), .rd_data(rdata0), .rd_valid(rdv0), .wr_done(wdn0), .err(err0)
  );

  assign m_busy  = use0 ? busy0  : busy1;
  assign m_rdv   = use0 ? rdv0   : rdv1;
  assign m_wdn   = use0 ? wdn0   : wdn1;
  assign m_err   = use0 ? err0   : err1;
  assign m_rdata = use0 ? rdata0 : rdata1;

  task automatic drive(input logic r, input logic w, input logic [8:0] a,
                       input logic [31:0] d, input logic [2:0] f3);
    if (use0) begin rd0 = r; wr0 = w; addr0 = a; wdat0 = d; f30 = f3; end
    else      begin rd1 = r; wr1 = w; addr1 = a; wdat1 = d; f31 = f3; end
  endtask

  // One request; returns busy cycle count, cycle of the response, pulses {rd_valid,wr_done,err}, data
  task automatic access(input logic r, input logic w, input logic [8:0] a, input logic [31:0] d,
                        input logic [2:0] f3, output int nb, output int ra,
                        output logic [2:0] p, output logic [31:0] dat);
    @(negedge clk);
    drive(r, w, a, d, f3);
    @(negedge clk);
    drive(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
    nb = 0; ra = 0; p = 3'b000; dat = 32'h0;
    for (int i = 0; i < 20; i++) begin
      if (!m_busy) break;
      nb++;
      if (m_rdv || m_wdn || m_err) begin
        p   = p | {m_rdv, m_wdn, m_err};
        ra  = nb;
        dat = m_rdata;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy1); end
    n_cmp++; if ({rdv1, wdn1, err1} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses got %b want 000", {rdv1, wdn1, err1}); end
    n_cmp++; if (rdata1 !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data got %h want 0", rdata1); end
    n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL reset_busy_lat0 got %b want 0", busy0); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_load();
    int nb, ra; logic [2:0] p; logic [31:0] dat;
    access(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'd2, nb, ra, p, dat);
    n_cmp++; if (nb !== 3) begin n_bad++; $display("FAIL sw_busy_cycles got %0d want 3", nb); end
    n_cmp++; if (ra !== 3) begin n_bad++; $display("FAIL sw_resp_cycle got %0d want 3", ra); end
    n_cmp++; if (p !== 3'b010) begin n_bad++; $display("FAIL sw_pulses got %b want 010", p); end
    access(1'b1, 1'b0, 9'h010, 32'h0, 3'd2, nb, ra, p, dat);
    n_cmp++; if (nb !== 3 || ra !== 3) begin n_bad++; $display("FAIL lw_timing got %0d/%0d want 3/3", nb, ra); end
    n_cmp++; if (p !== 3'b100) begin n_bad++; $display("FAIL lw_pulses got %b want 100", p); end
    n_cmp++; if (dat !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_data got %h want deadbeef", dat); end
    n_cmp++; if (rdata1 !== 32'hDEADBEEF) begin n_bad++; $display("FAIL lw_hold got %h want deadbeef", rdata1); end
  endtask

  task automatic test_sub_word();
    int nb, ra; logic [2:0] p; logic [31:0] dat;
    logic [8:0]  ta [6] = '{9'h013, 9'h013, 9'h012, 9'h010, 9'h010, 9'h011};
    logic [2:0]  tf [6] = '{3'd0, 3'd4, 3'd5, 3'd1, 3'd0, 3'd4};
    logic [31:0] te [6] = '{32'hFFFFFFDE, 32'h000000DE, 32'h0000DEAD, 32'hFFFFBEEF, 32'hFFFFFFEF, 32'h000000BE};
    for (int i = 0; i < 6; i++) begin
      access(1'b1, 1'b0, ta[i], 32'h0, tf[i], nb, ra, p, dat);
      n_cmp++; if (p !== 3'b100 || dat !== te[i]) begin n_bad++; $display("FAIL subword_%0d got %b/%h want 100/%h", i, p, dat, te[i]); end
    end
  endtask

  task automatic test_illegal();
    int nb, ra; logic [2:0] p; logic [31:0] dat;
    logic       tr [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [8:0] ta [7] = '{9'h011, 9'h012, 9'h013, 9'h010, 9'h010, 9'h010, 9'h010};
    logic [2:0] tf [7] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd4, 3'd5};
    for (int i = 0; i < 7; i++) begin
      access(tr[i], ~tr[i], ta[i], 32'h0000FFFF, tf[i], nb, ra, p, dat);
      n_cmp++; if (p !== 3'b001 || dat !== 32'h0 || ra !== 3) begin n_bad++; $display("FAIL illegal_%0d got %b/%h/%0d want 001/0/3", i, p, dat, ra); end
    end
    access(1'b1, 1'b0, 9'h010, 32'h0, 3'd2, nb, ra, p, dat);
    n_cmp++; if (dat !== 32'hDEADBEEF) begin n_bad++; $display("FAIL illegal_unchanged got %h want deadbeef", dat); end
  endtask

  task automatic test_rd_wr_both();
    int nb, ra; logic [2:0] p; logic [31:0] dat;
    access(1'b0, 1'b1, 9'h020, 32'h0, 3'd2, nb, ra, p, dat);
    access(1'b1, 1'b1, 9'h020, 32'h00000055, 3'd0, nb, ra, p, dat);
    n_cmp++; if (p !== 3'b010) begin n_bad++; $display("FAIL both_pulses got %b want 010", p); end
    access(1'b1, 1'b0, 9'h020, 32'h0, 3'd4, nb, ra, p, dat);
    n_cmp++; if (dat !== 32'h00000055) begin n_bad++; $display("FAIL both_lbu got %h want 55", dat); end
    access(1'b0, 1'b1, 9'h022, 32'h7777A1B2, 3'd1, nb, ra, p, dat);
    access(1'b1, 1'b0, 9'h020, 32'h0, 3'd2, nb, ra, p, dat);
    n_cmp++; if (dat !== 32'hA1B20055) begin n_bad++; $display("FAIL sh_merge got %h want a1b20055", dat); end
  endtask

  task automatic test_no_wrap();
    int nb, ra; logic [2:0] p; logic [31:0] dat;
    access(1'b0, 1'b1, 9'h000, 32'h11223344, 3'd2, nb, ra, p, dat);
    access(1'b0, 1'b1, 9'h1FC, 32'hCAFEF00D, 3'd2, nb, ra, p, dat);
    access(1'b1, 1'b0, 9'h1FC, 32'h0, 3'd2, nb, ra, p, dat);
    n_cmp++; if (dat !== 32'hCAFEF00D) begin n_bad++; $display("FAIL top_word got %h want cafef00d", dat); end
    access(1'b1, 1'b0, 9'h1FF, 32'h0, 3'd4, nb, ra, p, dat);
    n_cmp++; if (dat !== 32'h000000CA) begin n_bad++; $display("FAIL top_byte got %h want ca", dat); end
    access(1'b1, 1'b0, 9'h000, 32'h0, 3'd2, nb, ra, p, dat);
    n_cmp++; if (dat !== 32'h11223344) begin n_bad++; $display("FAIL no_wrap got %h want 11223344", dat); end
  endtask

  task automatic test_latency0();
    int nb, ra, nbusy, nval; logic [2:0] p; logic [31:0] dat;
    use0 = 1'b1;
    access(1'b0, 1'b1, 9'h040, 32'h13579BDF, 3'd2, nb, ra, p, dat);
    n_cmp++; if (nb !== 1 || ra !== 1 || p !== 3'b010) begin n_bad++; $display("FAIL lat0_sw got %0d/%0d/%b want 1/1/010", nb, ra, p); end
    access(1'b1, 1'b0, 9'h040, 32'h0, 3'd2, nb, ra, p, dat);
    n_cmp++; if (nb !== 1 || p !== 3'b100 || dat !== 32'h13579BDF) begin n_bad++; $display("FAIL lat0_lw got %0d/%b/%h want 1/100/13579bdf", nb, p, dat); end
    @(negedge clk);
    drive(1'b1, 1'b0, 9'h042, 32'h0, 3'd5);
    nbusy = 0; nval = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy0) nbusy++;
      if (rdv0) begin
        nval++;
        n_cmp++; if (rdata0 !== 32'h00001357) begin n_bad++; $display("FAIL lat0_b2b_data got %h want 1357", rdata0); end
      end
      if (i == 1) begin
        n_cmp++; if (busy0 !== 1'b0) begin n_bad++; $display("FAIL lat0_gap got %b want 0", busy0); end
      end
    end
    drive(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
    n_cmp++; if (nval !== 4 || nbusy !== 4) begin n_bad++; $display("FAIL lat0_b2b_rate got %0d/%0d want 4/4", nval, nbusy); end
    @(negedge clk);
    use0 = 1'b0;
  endtask

  task automatic test_reset_abort();
    int nb, ra; logic [2:0] p; logic [31:0] dat; logic seen;
    access(1'b0, 1'b1, 9'h030, 32'h0BADF00D, 3'd2, nb, ra, p, dat);
    access(1'b1, 1'b0, 9'h000, 32'h0, 3'd2, nb, ra, p, dat);
    @(negedge clk);
    drive(1'b0, 1'b1, 9'h030, 32'h12345678, 3'd2);
    @(negedge clk);
    drive(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
    n_cmp++; if (busy1 !== 1'b1) begin n_bad++; $display("FAIL abort_inflight got %b want 1", busy1); end
    reset = 1'b0;
    #1;
    n_cmp++; if (busy1 !== 1'b0 || rdata1 !== 32'h0) begin n_bad++; $display("FAIL abort_async got %b/%h want 0/0", busy1, rdata1); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wdn1 || rdv1 || err1) seen = 1'b1;
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (wdn1 || rdv1 || err1 || busy1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_pulse got %b want 0", seen); end
    access(1'b1, 1'b0, 9'h030, 32'h0, 3'd2, nb, ra, p, dat);
    n_cmp++; if (dat !== 32'h0BADF00D) begin n_bad++; $display("FAIL abort_mem got %h want 0badf00d", dat); end
    access(1'b1, 1'b0, 9'h010, 32'h0, 3'd2, nb, ra, p, dat);
    n_cmp++; if (dat !== 32'hDEADBEEF) begin n_bad++; $display("FAIL mem_kept got %h want deadbeef", dat); end
  endtask

  initial begin
    use0 = 1'b0;
    reset = 1'b1;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 9'h0; wdat1 = 32'h0; f31 = 3'd0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = 9'h0; wdat0 = 32'h0; f30 = 3'd0;
    test_reset();
    test_store_load();
    test_sub_word();
    test_illegal();
    test_rd_wr_both();
    test_no_wrap();
    test_latency0();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
